// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer:
// aluop codes, FSM state encoding and op-decode helpers.
package mdu_ctrl_pkg;

  localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    MDU_IDLE    = 2'd0,
    MDU_DIV_RUN = 2'd1,
    MDU_DONE    = 2'd2
  } mdu_state_e;

  function automatic logic is_mdu_op(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
           (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
  endfunction

  function automatic logic is_mult_op(input logic [7:0] op);
    return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
  endfunction

endpackage

// File: rtl/mdu_ctrl_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// quotient/remainder show the result of the step taken at the coming edge.
import mdu_ctrl_pkg::*;

module div_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [DATA_W-1:0] quo_r;
  logic [DATA_W-1:0] rem_r;
  logic [DATA_W-1:0] div_r;
  logic [DATA_W:0]   partial_s;
  logic [DATA_W:0]   diff_s;
  logic              qbit_s;

  // Trial subtraction; bit DATA_W of the difference is the borrow.
  always_comb begin
    partial_s = {rem_r, quo_r[DATA_W-1]};
    diff_s    = partial_s - {1'b0, div_r};
    if (!diff_s[DATA_W]) begin
      qbit_s    = 1'b1;
      remainder = diff_s[DATA_W-1:0];
    end else begin
      qbit_s    = 1'b0;
      remainder = partial_s[DATA_W-1:0];
    end
    quotient = {quo_r[DATA_W-2:0], qbit_s};
  end

  // Operand load or one shift/subtract step per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      quo_r <= {DATA_W{1'b0}};
      rem_r <= {DATA_W{1'b0}};
      div_r <= {DATA_W{1'b0}};
    end else if (load) begin
      quo_r <= dividend;
      rem_r <= {DATA_W{1'b0}};
      div_r <= divisor;
    end else begin
      quo_r <= quotient;
      rem_r <= remainder;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer: single-cycle multiply, iterative
// signed/unsigned divide, pipeline stall and one-cycle HI/LO write strobe.
import mdu_ctrl_pkg::*;

module mdu_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [7:0]        aluop_i,
  input  logic [DATA_W-1:0] src_a_i,
  input  logic [DATA_W-1:0] src_b_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              hilo_we_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  mdu_state_e          state_r;
  mdu_state_e          state_s;
  logic [CNT_W-1:0]    counter_r;
  logic                neg_q_r;
  logic                neg_rem_r;
  logic                accept_s;
  logic                is_mult_s;
  logic                mult_signed_s;
  logic                div_signed_s;
  logic                div_zero_s;
  logic                div_load_s;
  logic                div_last_s;
  logic [2*DATA_W-1:0] mul_a_s;
  logic [2*DATA_W-1:0] mul_b_s;
  logic [2*DATA_W-1:0] product_s;
  logic [DATA_W-1:0]   abs_a_s;
  logic [DATA_W-1:0]   abs_b_s;
  logic [DATA_W-1:0]   quo_s;
  logic [DATA_W-1:0]   rem_s;

  assign accept_s      = (state_r == MDU_IDLE) && start_i && is_mdu_op(aluop_i) && !flush_i;
  assign is_mult_s     = is_mult_op(aluop_i);
  assign mult_signed_s = (aluop_i == EXE_MULT_OP);
  assign div_signed_s  = (aluop_i == EXE_DIV_OP);
  assign div_zero_s    = (src_b_i == {DATA_W{1'b0}});
  assign div_last_s    = (state_r == MDU_DIV_RUN) && (counter_r == CNT_LAST) && !flush_i;

  // Sign-extending for MULT lets one unsigned multiplier serve both flavours.
  assign mul_a_s   = {{DATA_W{mult_signed_s & src_a_i[DATA_W-1]}}, src_a_i};
  assign mul_b_s   = {{DATA_W{mult_signed_s & src_b_i[DATA_W-1]}}, src_b_i};
  assign product_s = mul_a_s * mul_b_s;

  assign abs_a_s = (div_signed_s && src_a_i[DATA_W-1]) ? -src_a_i : src_a_i;
  assign abs_b_s = (div_signed_s && src_b_i[DATA_W-1]) ? -src_b_i : src_b_i;

  assign stall_o   = accept_s || (state_r == MDU_DIV_RUN);
  assign busy_o    = (state_r != MDU_IDLE);
  assign hilo_we_o = (state_r == MDU_DONE) && !flush_i;

  div_core #(.DATA_W(DATA_W)) u_div_core (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load_s),
    .dividend  (abs_a_s),
    .divisor   (abs_b_s),
    .quotient  (quo_s),
    .remainder (rem_s)
  );

  // Next-state decode; flush wins over everything, including a new start.
  always_comb begin
    state_s    = state_r;
    div_load_s = 1'b0;
    case (state_r)
      MDU_IDLE: begin
        if (accept_s) begin
          if (is_mult_s || div_zero_s) begin
            state_s = MDU_DONE;
          end else begin
            state_s    = MDU_DIV_RUN;
            div_load_s = 1'b1;
          end
        end else begin
          state_s = MDU_IDLE;
        end
      end
      MDU_DIV_RUN: begin
        if (flush_i) begin
          state_s = MDU_IDLE;
        end else if (counter_r == CNT_LAST) begin
          state_s = MDU_DONE;
        end else begin
          state_s = MDU_DIV_RUN;
        end
      end
      MDU_DONE: state_s = MDU_IDLE;
      default:  state_s = MDU_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= MDU_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Result, sign-flag and iteration-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter_r <= {CNT_W{1'b0}};
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      hi_o      <= {DATA_W{1'b0}};
      lo_o      <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      counter_r <= {CNT_W{1'b0}};
      if (is_mult_s) begin
        {hi_o, lo_o} <= product_s;
      end else if (div_zero_s) begin
        hi_o <= src_a_i;
        lo_o <= {DATA_W{1'b1}};
      end else begin
        neg_q_r   <= div_signed_s && (src_a_i[DATA_W-1] != src_b_i[DATA_W-1]);
        neg_rem_r <= div_signed_s && src_a_i[DATA_W-1];
      end
    end else if (state_r == MDU_DIV_RUN && !flush_i) begin
      counter_r <= counter_r + 1'b1;
      if (div_last_s) begin
        lo_o <= neg_q_r   ? -quo_s : quo_s;
        hi_o <= neg_rem_r ? -rem_s : rem_s;
      end else begin
        lo_o <= lo_o;
        hi_o <= hi_o;
      end
    end else begin
      counter_r <= counter_r;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed self-checking bench for mdu_ctrl: multiply/divide results,
// stall/write timing, flush, reset and non-mdu op handling.
`timescale 1ns/1ps
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  aluop_i;
  logic [31:0] src_a_i;
  logic [31:0] src_b_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        hilo_we_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mdu_ctrl #(.DIV_CYCLES(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .aluop_i   (aluop_i),
    .src_a_i   (src_a_i),
    .src_b_i   (src_b_i),
    .flush_i   (flush_i),
    .stall_o   (stall_o),
    .busy_o    (busy_o),
    .hilo_we_o (hilo_we_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Start an op at cycle T=0 and hold start_i until the edge that ends DONE.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int stalls;
    int wes;
    int we_at;
    stalls = 0;
    wes    = 0;
    we_at  = -1;
    start_i = 1'b1; aluop_i = op; src_a_i = a; src_b_i = b;
    for (int c = 0; c <= lat + 2; c++) begin
      if (c > 0) next_cycle();
      if (we_at >= 0 && c == we_at + 1) start_i = 1'b0;
      #1;
      if (stall_o) stalls++;
      if (hilo_we_o) begin
        wes++;
        we_at = c;
        check_eq({tag, "_hi"}, hi_o, exp_hi);
        check_eq({tag, "_lo"}, lo_o, exp_lo);
      end
    end
    start_i = 1'b0;
    check_eq({tag, "_stall_cycles"}, 32'(stalls), 32'(lat));
    check_eq({tag, "_we_pulses"}, 32'(wes), 32'd1);
    check_eq({tag, "_we_cycle"}, 32'(we_at), 32'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int wes;
    rst = 1'b1; start_i = 1'b0; aluop_i = 8'h00; src_a_i = 32'h0; src_b_i = 32'h0; flush_i = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b0;
    #1;
    check_eq("rst_stall", {31'h0, stall_o}, 32'h0);
    check_eq("rst_busy", {31'h0, busy_o}, 32'h0);
    check_eq("rst_we", {31'h0, hilo_we_o}, 32'h0);
    check_eq("rst_hi", hi_o, 32'h0);
    check_eq("rst_lo", lo_o, 32'h0);

    next_cycle();
    run_op("mult_neg3x5", EXE_MULT_OP, 32'hFFFF_FFFD, 32'd5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu_max_x2", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'd2, 1, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("multu_max_sq", EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_neg7_2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_neg2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_100_7", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    run_op("div_min_neg1", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
    run_op("divu_by0", EXE_DIVU_OP, 32'd9, 32'd0, 1, 32'd9, 32'hFFFF_FFFF);

    // Non-mdu op must neither stall nor start the unit.
    start_i = 1'b1; aluop_i = EXE_ADD_OP; src_a_i = 32'd3; src_b_i = 32'd4;
    #1;
    check_eq("add_stall", {31'h0, stall_o}, 32'h0);
    next_cycle();
    check_eq("add_busy", {31'h0, busy_o}, 32'h0);
    check_eq("add_we", {31'h0, hilo_we_o}, 32'h0);
    start_i = 1'b0;

    // Flush has priority over a start in IDLE.
    start_i = 1'b1; aluop_i = EXE_MULT_OP; flush_i = 1'b1;
    #1;
    check_eq("flush_idle_stall", {31'h0, stall_o}, 32'h0);
    next_cycle();
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    check_eq("flush_idle_busy", {31'h0, busy_o}, 32'h0);
    check_eq("flush_idle_hold_lo", lo_o, 32'hFFFF_FFFF);

    // DIVU flushed at T+10, then a fresh DIVU at T+12.
    next_cycle();
    wes = 0;
    start_i = 1'b1; aluop_i = EXE_DIVU_OP; src_a_i = 32'd200; src_b_i = 32'd3;
    #1;
    check_eq("flush_run_stall_T", {31'h0, stall_o}, 32'h1);
    for (int c = 1; c <= 11; c++) begin
      next_cycle();
      if (c == 10) flush_i = 1'b1;
      if (c == 11) begin flush_i = 1'b0; start_i = 1'b0; end
      #1;
      if (hilo_we_o) wes++;
    end
    check_eq("flush_run_stall_T11", {31'h0, stall_o}, 32'h0);
    check_eq("flush_run_busy_T11", {31'h0, busy_o}, 32'h0);
    next_cycle();
    run_op("divu_after_flush", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd2, 32'd14);
    check_eq("flush_run_no_we", 32'(wes), 32'd0);

    // DIVU interrupted by reset at T+10.
    next_cycle();
    start_i = 1'b1; aluop_i = EXE_DIVU_OP; src_a_i = 32'd50; src_b_i = 32'd6;
    for (int c = 1; c <= 11; c++) begin
      next_cycle();
      if (c == 10) rst = 1'b1;
      if (c == 11) begin rst = 1'b0; start_i = 1'b0; end
      #1;
    end
    check_eq("rst_run_stall", {31'h0, stall_o}, 32'h0);
    check_eq("rst_run_busy", {31'h0, busy_o}, 32'h0);
    check_eq("rst_run_we", {31'h0, hilo_we_o}, 32'h0);
    check_eq("rst_run_hi", hi_o, 32'h0);
    check_eq("rst_run_lo", lo_o, 32'h0);

    next_cycle();
    run_op("mult_after_rst", EXE_MULT_OP, 32'd6, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
